// File: rtl/dsa_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Optional build macro DSA_SATURATE_EN is consumed by digit_serial_adder.
package dsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } dsa_state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int dsa_ndig(input int width, input int digit);
      return width / digit;
   endfunction

   // The digit index is never narrower than one bit, even when a single slice covers the whole word.
   function automatic int dsa_idx_w(input int width, input int digit);
      int n;
      n = width / digit;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice shared by every digit of an operation.
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout
);

   logic [DIGIT:0] c;

   // Explicit bit-by-bit ripple so the slice maps onto a simple full-adder chain.
   always_comb begin
      c[0] = cin;
      sum  = '0;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
      cout = c[DIGIT];
   end

endmodule

// File: rtl/digit_serial_adder.sv
// WIDTH-bit add/subtract computed DIGIT bits per clock with valid/ready handshakes.
// Define DSA_SATURATE_EN to replace overflowing results with the signed saturation value.
module digit_serial_adder
   import dsa_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             carry,
   output logic             ovf,
   output logic             busy,
   output logic [WIDTH-1:0] disp_a,
   output logic [WIDTH-1:0] disp_b
);

   localparam int NDIG = dsa_ndig(WIDTH, DIGIT);
   localparam int IDXW = dsa_idx_w(WIDTH, DIGIT);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

   dsa_state_e       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] beff_reg;
   logic [WIDTH-1:0] y_reg;
   logic [WIDTH-1:0] y_next;
   logic [IDXW-1:0]  k;
   logic             carry_reg;
   logic             carry_flag;
   logic             ovf_flag;
   logic             ovf_next;
   logic             last;
   logic [DIGIT-1:0] a_slice;
   logic [DIGIT-1:0] b_slice;
   logic [DIGIT-1:0] sum;
   logic             cout;

   assign in_ready  = (state == IDLE);
   assign busy      = (state == RUN);
   assign out_valid = (state == DONE);
   assign y         = y_reg;
   assign carry     = carry_flag;
   assign ovf       = ovf_flag;
   assign last      = (k == LAST_IDX);

   assign a_slice = a_reg[k*DIGIT +: DIGIT];
   assign b_slice = beff_reg[k*DIGIT +: DIGIT];

   digit_adder #(
      .DIGIT(DIGIT)
   ) u_slice (
      .a   (a_slice),
      .b   (b_slice),
      .cin (carry_reg),
      .sum (sum),
      .cout(cout)
   );

   // Merge the current slice into the result; on the final slice this is also where
   // the overflow flag and the optional saturation value are settled.
   always_comb begin
      y_next                    = y_reg;
      y_next[k*DIGIT +: DIGIT]  = sum;
      ovf_next = (a_reg[WIDTH-1] == beff_reg[WIDTH-1]) &&
                 (y_next[WIDTH-1] != a_reg[WIDTH-1]);
`ifdef DSA_SATURATE_EN
      if (last && ovf_next) begin
         if (a_reg[WIDTH-1] == 1'b0) begin
            y_next = {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            y_next = {1'b1, {(WIDTH-1){1'b0}}};
         end
      end
`endif
   end

   // Capture in IDLE, one slice per RUN cycle, then hold the result until it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_reg      <= '0;
         beff_reg   <= '0;
         y_reg      <= '0;
         k          <= '0;
         carry_reg  <= 1'b0;
         carry_flag <= 1'b0;
         ovf_flag   <= 1'b0;
         disp_a     <= '0;
         disp_b     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg      <= a;
                  beff_reg   <= (op == OP_ADD) ? b : ~b;
                  carry_reg  <= (op == OP_SUB) ? 1'b1 : cin;
                  disp_a     <= a;
                  disp_b     <= b;
                  k          <= '0;
                  y_reg      <= '0;
                  carry_flag <= 1'b0;
                  ovf_flag   <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               y_reg     <= y_next;
               carry_reg <= cout;
               k         <= k + 1'b1;
               if (last) begin
                  carry_flag <= cout;
                  ovf_flag   <= ovf_next;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
